// File: rtl/matmul_addr_seq_pkg.sv
// Shared definitions for the matrix-multiply address sequencer: FSM state
// encoding, request-word field layout and the request-word packer.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B0,
    FETCH_B1,
    WAIT_RES,
    STORE,
    FINISH
  } state_t;

  localparam int WORD_W    = 16;
  localparam int BASE_MSB  = 15;
  localparam int BASE_LSB  = 8;
  localparam int AORB_BIT  = 7;
  localparam int NORK_MSB  = 6;
  localparam int NORK_LSB  = 0;

  function automatic logic [WORD_W-1:0] pack_word(input logic [7:0] base,
                                                  input logic       aorb,
                                                  input logic [6:0] nork);
    logic [WORD_W-1:0] w;
    w                     = '0;
    w[BASE_MSB:BASE_LSB]  = base;
    w[AORB_BIT]           = aorb;
    w[NORK_MSB:NORK_LSB]  = nork;
    return w;
  endfunction

endpackage

// File: rtl/matmul_addr_seq_if.sv
// Request-word bus between the sequencer (master) and its command/MAC side.
// Carries the abort input only when MATMUL_ADDR_SEQ_ABORT_EN is defined.
interface matmul_addr_seq_if;
  logic        start;
  logic        res_valid;
`ifdef MATMUL_ADDR_SEQ_ABORT_EN
  logic        abort;
`endif
  logic [15:0] address;
  logic        write_en;
  logic        word_valid;
  logic        k_last;
  logic        busy;
  logic        done;

`ifdef MATMUL_ADDR_SEQ_ABORT_EN
  modport master (
    input  start, res_valid, abort,
    output address, write_en, word_valid, k_last, busy, done
  );
  modport slave (
    output start, res_valid, abort,
    input  address, write_en, word_valid, k_last, busy, done
  );
`else
  modport master (
    input  start, res_valid,
    output address, write_en, word_valid, k_last, busy, done
  );
  modport slave (
    output start, res_valid,
    input  address, write_en, word_valid, k_last, busy, done
  );
`endif
endinterface

// File: rtl/matmul_addr_seq_hold_timer.sv
// Hold timer: reloads to HOLD_CYCLES-1 on load and counts down to zero;
// expire is high on the last clock of a hold.
module matmul_hold_timer #(
  parameter int HOLD_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [W-1:0] TOP = W'(HOLD_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TOP;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/matmul_addr_seq.sv
// Loop-nest command sequencer for C = A x B; emits held request words to the
// DRAM controller. Optional abort input via MATMUL_ADDR_SEQ_ABORT_EN.
module matmul_addr_seq
  import matmul_pkg::*;
#(
  parameter int         DIM         = 4,
  parameter int         HOLD_CYCLES = 3,
  parameter logic [7:0] A_BASE      = 8'h00,
  parameter logic [7:0] B_BASE      = 8'h10,
  parameter logic [7:0] C_BASE      = 8'h20
) (
  input logic               clk,
  input logic               rst,
  matmul_addr_seq_if.master bus
);

  localparam int            CW       = 4;
  localparam logic [7:0]    DIM8     = 8'(DIM);
  localparam logic [6:0]    DIM7     = 7'(DIM);
  localparam logic [CW-1:0] LAST_EVN = CW'(DIM - 2);
  localparam logic [CW-1:0] LAST_ROW = CW'(DIM - 1);
  localparam logic [CW-1:0] STEP     = CW'(2);

  state_t        state;
  logic [CW-1:0] i_q, jp_q, kp_q;
  logic [15:0]   address_q;
  logic          write_en_q, word_valid_q, k_last_q, busy_q, done_q;
  logic          load, expire;
  logic          kp_last, jp_last, i_last;

  function automatic logic [7:0] tile_base(input logic [7:0]    origin,
                                           input logic [CW-1:0] row,
                                           input logic [CW-1:0] col);
    return origin + 8'(row) * DIM8 + 8'(col);
  endfunction

  function automatic logic [15:0] a_word(input logic [CW-1:0] row,
                                         input logic [CW-1:0] col);
    return pack_word(tile_base(A_BASE, row, col), 1'b1, 7'd1);
  endfunction

  function automatic logic [15:0] b_word(input logic [CW-1:0] row,
                                         input logic [CW-1:0] col,
                                         input logic          odd);
    return pack_word(tile_base(B_BASE, row, col) + {7'd0, odd}, 1'b1, DIM7);
  endfunction

  function automatic logic [15:0] c_word(input logic [CW-1:0] row,
                                         input logic [CW-1:0] col);
    return pack_word(tile_base(C_BASE, row, col), 1'b0, 7'd1);
  endfunction

  assign kp_last = (kp_q == LAST_EVN);
  assign jp_last = (jp_q == LAST_EVN);
  assign i_last  = (i_q == LAST_ROW);

  // Timer reloads exactly on the edges that enter a held state.
  always_comb begin
    load = 1'b0;
    case (state)
      IDLE:              load = bus.start;
      FETCH_A, FETCH_B0: load = expire;
      FETCH_B1:          load = expire && !kp_last;
      WAIT_RES:          load = bus.res_valid;
      STORE:             load = expire && !(i_last && jp_last);
      default:           load = 1'b0;
    endcase
  end

  matmul_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      i_q          <= '0;
      jp_q         <= '0;
      kp_q         <= '0;
      address_q    <= '0;
      write_en_q   <= 1'b0;
      word_valid_q <= 1'b0;
      k_last_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
`ifdef MATMUL_ADDR_SEQ_ABORT_EN
      if (bus.abort && busy_q) begin
        state        <= IDLE;
        i_q          <= '0;
        jp_q         <= '0;
        kp_q         <= '0;
        write_en_q   <= 1'b0;
        word_valid_q <= 1'b0;
        k_last_q     <= 1'b0;
        busy_q       <= 1'b0;
      end else
`endif
      begin
        case (state)
          IDLE: if (bus.start) begin
            state        <= FETCH_A;
            busy_q       <= 1'b1;
            word_valid_q <= 1'b1;
            address_q    <= a_word(i_q, kp_q);
          end
          FETCH_A: if (expire) begin
            state     <= FETCH_B0;
            address_q <= b_word(kp_q, jp_q, 1'b0);
          end
          FETCH_B0: if (expire) begin
            state     <= FETCH_B1;
            address_q <= b_word(kp_q, jp_q, 1'b1);
            k_last_q  <= kp_last;
          end
          FETCH_B1: if (expire) begin
            k_last_q <= 1'b0;
            if (kp_last) begin
              state        <= WAIT_RES;
              word_valid_q <= 1'b0;
              kp_q         <= '0;
            end else begin
              state     <= FETCH_A;
              kp_q      <= kp_q + STEP;
              address_q <= a_word(i_q, kp_q + STEP);
            end
          end
          WAIT_RES: if (bus.res_valid) begin
            state        <= STORE;
            word_valid_q <= 1'b1;
            write_en_q   <= 1'b1;
            address_q    <= c_word(i_q, jp_q);
          end
          STORE: if (expire) begin
            write_en_q <= 1'b0;
            if (i_last && jp_last) begin
              state        <= FINISH;
              word_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              i_q          <= '0;
              jp_q         <= '0;
            end else if (jp_last) begin
              state     <= FETCH_A;
              i_q       <= i_q + CW'(1);
              jp_q      <= '0;
              address_q <= a_word(i_q + CW'(1), '0);
            end else begin
              state     <= FETCH_A;
              jp_q      <= jp_q + STEP;
              address_q <= a_word(i_q, '0);
            end
          end
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.address    = address_q;
  assign bus.write_en   = write_en_q;
  assign bus.word_valid = word_valid_q;
  assign bus.k_last     = k_last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_matmul_addr_seq.sv
// Directed, cycle-exact bench for matmul_addr_seq with a queued reference of
// request words; abort steps compile in with MATMUL_ADDR_SEQ_ABORT_EN.
module tb_matmul_addr_seq;
  import matmul_pkg::*;

  localparam int DIM  = 4;
  localparam int HOLD = 3;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic        kl;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  matmul_addr_seq_if bus();

  matmul_addr_seq #(
    .DIM        (DIM),
    .HOLD_CYCLES(HOLD),
    .A_BASE     (8'h00),
    .B_BASE     (8'h10),
    .C_BASE     (8'h20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          vcyc  = 0;
  int          dcnt  = 0;
  logic [15:0] last_addr = '0;
  word_t       exp_q[$];

  always @(negedge clk) begin
    if (rst) begin
      vcyc = 0;
      dcnt = 0;
    end else begin
      if (bus.word_valid === 1'b1) vcyc++;
      if (bus.done === 1'b1) dcnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t mk(input int base, input logic aorb, input int nork,
                               input logic we, input logic kl);
    word_t w;
    w.addr = {8'(base), aorb, 7'(nork)};
    w.we   = we;
    w.kl   = kl;
    return w;
  endfunction

  task automatic fill_model();
    exp_q.delete();
    for (int i = 0; i < DIM; i++) begin
      for (int jp = 0; jp < DIM; jp += 2) begin
        for (int kp = 0; kp < DIM; kp += 2) begin
          exp_q.push_back(mk('h00 + i*DIM + kp, 1'b1, 1, 1'b0, 1'b0));
          exp_q.push_back(mk('h10 + kp*DIM + jp, 1'b1, DIM, 1'b0, 1'b0));
          exp_q.push_back(mk('h10 + kp*DIM + jp + 1, 1'b1, DIM, 1'b0, kp == DIM-2));
        end
        exp_q.push_back(mk('h20 + i*DIM + jp, 1'b0, 1, 1'b1, 1'b0));
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_addr"}, 32'(bus.address), 0);
    chk({tag, "_we"},   32'(bus.write_en), 0);
    chk({tag, "_wv"},   32'(bus.word_valid), 0);
    chk({tag, "_kl"},   32'(bus.k_last), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
  endtask

  // Checks one held word over all its cycles; poke drives start and res_valid
  // during the first cycle, which must have no effect.
  task automatic run_word(input string tag, input bit poke);
    word_t w;
    w = exp_q.pop_front();
    last_addr = w.addr;
    for (int c = 0; c < HOLD; c++) begin
      chk({tag, "_addr"}, 32'(bus.address), 32'(w.addr));
      chk({tag, "_we"},   32'(bus.write_en), 32'(w.we));
      chk({tag, "_wv"},   32'(bus.word_valid), 1);
      chk({tag, "_kl"},   32'(bus.k_last), 32'(w.kl));
      if (c == 0 && poke) begin
        bus.start     = 1'b1;
        bus.res_valid = 1'b1;
      end
      @(negedge clk);
      bus.start     = 1'b0;
      bus.res_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.res_valid = 1'b0;
`ifdef MATMUL_ADDR_SEQ_ABORT_EN
    bus.abort     = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check_idle("start_with_rst_lost");

    // Full multiply; res_valid and start poked during a FETCH_A of pair 1.
    fill_model();
    pulse_start();
    chk("busy_rise", 32'(bus.busy), 1);
    for (int p = 0; p < (DIM/2)*DIM; p++) begin
      for (int w = 0; w < 3*(DIM/2); w++) run_word("fetch", (p == 1) && (w == 0));
      for (int c = 0; c < (p % 3) + 1; c++) begin
        chk("wait_wv",   32'(bus.word_valid), 0);
        chk("wait_we",   32'(bus.write_en), 0);
        chk("wait_addr", 32'(bus.address), 32'(last_addr));
        chk("wait_busy", 32'(bus.busy), 1);
        @(negedge clk);
      end
      bus.res_valid = 1'b1;
      @(negedge clk);
      bus.res_valid = 1'b0;
      run_word("store", 1'b0);
    end
    chk("last_word",  32'(last_addr), 32'h2E01);
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_busy",  32'(bus.busy), 0);
    chk("done_wv",    32'(bus.word_valid), 0);
    @(negedge clk);
    chk("done_once", 32'(bus.done), 0);
    repeat (3) @(negedge clk);
    chk("done_count",   32'(dcnt), 1);
    chk("valid_cycles", 32'(vcyc), 32'(((DIM/2)*DIM*(3*(DIM/2)+1))*HOLD));

    // Reset during the second FETCH_B0 hold, then restart.
    fill_model();
    pulse_start();
    for (int w = 0; w < 4; w++) run_word("pre_rst", 1'b0);
    chk("pre_rst_b0", 32'(bus.address), 32'h1884);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid_rst");
    @(negedge clk);
    check_idle("mid_rst_hold");
    fill_model();
    pulse_start();
    run_word("restart", 1'b0);
    run_word("restart", 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef MATMUL_ADDR_SEQ_ABORT_EN
    fill_model();
    pulse_start();
    for (int w = 0; w < 3*(DIM/2); w++) run_word("ab_fetch", 1'b0);
    bus.res_valid = 1'b1;
    @(negedge clk);
    bus.res_valid = 1'b0;
    chk("ab_store_we", 32'(bus.write_en), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("ab_busy", 32'(bus.busy), 0);
    chk("ab_we",   32'(bus.write_en), 0);
    chk("ab_wv",   32'(bus.word_valid), 0);
    chk("ab_kl",   32'(bus.k_last), 0);
    chk("ab_done", 32'(bus.done), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ab_no_done", 32'(bus.done), 0);
      chk("ab_idle_wv", 32'(bus.word_valid), 0);
    end
    fill_model();
    pulse_start();
    run_word("ab_restart", 1'b0);
    run_word("ab_restart", 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matmul_addr_seq.md
Name: matmul_addr_seq

Overview:
- Upstream command sequencer for the DRAM access controller in the matrix-multiply datapath.
- Walks the loop nest for C = A x B over DIM x DIM byte matrices in DRAM.
- Emits 16-bit request words {base[7:0], AorB, NorK[6:0]} plus write_en, each held stable for HOLD_CYCLES clocks so the controller's 3-phase fetch/store cycle can consume it.
- Paces result stores on a MAC-ready input.

Parameters:
- DIM, 4: matrix dimension; must be even, 2..8.
- HOLD_CYCLES, 3: clocks each request word is held; minimum 3.
- A_BASE, 8'h00: DRAM byte address of A[0][0], row-major.
- B_BASE, 8'h10: DRAM byte address of B[0][0], row-major.
- C_BASE, 8'h20: DRAM byte address of C[0][0], row-major.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a multiply; ignored unless idle.
- res_valid  in  1  MAC pulse: results C[i][j] and C[i][j+1] are ready to store.
- address  out  16  request word to the DRAM controller.
- write_en  out  1  1 = store request, 0 = fetch request.
- word_valid  out  1  high while a request word is being held.
- k_last  out  1  high during the final B1 word of an element pair; used by the MAC to finalise.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final store hold completes.

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all outputs 0; all loop counters 0. The same applies mid-operation, and any in-flight word is dropped.
- Loop order: i = 0..DIM-1; jp = 0,2,..,DIM-2; kp = 0,2,..,DIM-2.
- Per kp, three words are issued in this order:
  - A: base = A_BASE + i*DIM + kp; AorB = 1; NorK = 1.
  - B0: base = B_BASE + kp*DIM + jp; AorB = 1; NorK = DIM.
  - B1: as B0 with base + 1.
- After the last kp of a jp pair:
  - Enter WAIT_RES.
  - On res_valid, issue a store word: base = C_BASE + i*DIM + jp; AorB = 0; NorK = 1; write_en = 1.
- Base arithmetic is 8-bit modulo 256; no overflow detection. The bases are configured so that base + DIM*DIM <= 256.
- States: IDLE, FETCH_A, FETCH_B0, FETCH_B1, WAIT_RES, STORE, FINISH.
  - IDLE --start--> FETCH_A.
  - Each FETCH_* and STORE holds for HOLD_CYCLES, then advances:
    - FETCH_A -> FETCH_B0 -> FETCH_B1.
    - FETCH_B1 -> FETCH_A (next kp), or WAIT_RES if kp is last.
  - WAIT_RES --res_valid--> STORE.
  - STORE -> FETCH_A (next jp/i), or FINISH if i = DIM-1 and jp = DIM-2.
  - FINISH: done = 1 for one cycle, then IDLE.
- Latency: the first word appears on address the cycle after start is sampled, with word_valid = 1.
- The hold counter counts 0..HOLD_CYCLES-1. address and write_en change only on the cycle after the count wraps.
- Between words, word_valid stays high; the next word is presented back-to-back with no gap.
- In WAIT_RES: word_valid = 0, address holds its last value, write_en = 0.
- res_valid outside WAIT_RES is ignored and not queued.
- start during busy is ignored. A start in the same cycle as rst is lost.
- write_en is 1 only in STORE.

Optional Feature:
- Macro: MATMUL_ADDR_SEQ_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - If abort = 1 at a posedge while busy, the next state is IDLE and busy, word_valid, write_en and k_last are cleared. done is not pulsed.
  - rst has priority over abort.
- When undefined: no abort port; the sequence always runs to FINISH.

Decomposition:
- Shared package matmul_pkg holds:
  - The state encoding.
  - Request-word field positions: base [15:8], AorB [7], NorK [6:0].
  - The function/macro packing a request word from base, AorB and NorK.
- One natural sub-module, matmul_hold_timer: the HOLD_CYCLES down-counter with load/expire outputs.

Test Plan (DIM=4, HOLD_CYCLES=3, bases 00/10/20 unless stated):
- Reset then start -> busy rises next cycle; words in order:
  - 0081, 1084, 1184, 0281, 1884, 1984, each held exactly 3 cycles, write_en = 0.
  - Then word_valid = 0 in WAIT_RES.
- Pulse res_valid in WAIT_RES -> word 2001 with write_en = 1 for 3 cycles; next word 0081, then 1284.
- Full run, res_valid pulsed on every WAIT_RES entry:
  - 56 words in total; last word 2E01.
  - done pulses once, busy falls with it.
- rst asserted during the second FETCH_B0 hold -> next cycle all outputs 0, state IDLE; a fresh start restarts at 0081.
- start re-pulsed while busy, and res_valid pulsed during FETCH_A -> no change to the word sequence or its timing.
- With MATMUL_ADDR_SEQ_ABORT_EN: abort during STORE -> next cycle busy = 0, write_en = 0, no done pulse; start then restarts at 0081.
